// File: rtl/dcim_macro_driver.sv
// rtl/dcim_macro_driver.sv - host-side command/response driver for the DCIM macro
module dcim_macro_driver #(
    parameter int WR_CYC  = 2,
    parameter int RES_DLY = 1,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         w_valid,
    output logic         w_ready,
    input  logic [23:0]  w_data,
    input  logic [7:0]   w_addr,
    input  logic         w_bank,
    input  logic         c_valid,
    output logic         c_ready,
    input  logic [191:0] c_xin,
    input  logic         c_bank,
    input  logic         c_inwidth,
    input  logic         c_wwidth,
    input  logic         c_acc,
    output logic         r_valid,
    input  logic         r_ready,
    output logic [50:0]  r_data,
    output logic         r_err,
    output logic [23:0]  m_D,
    output logic [7:0]   m_WA,
    output logic         m_cima,
    output logic         m_start,
    output logic [191:0] m_xin0,
    output logic         m_inwidth,
    output logic         m_wwidth,
    output logic         m_acm_en,
    input  logic [50:0]  m_nout,
    input  logic         m_st
);

    localparam int CW = $clog2(WR_CYC + RES_DLY + TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_START,
        S_BUSY,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic          w_take;
    logic          c_take;
    logic          cap_take;
    logic          tmo_take;

    // One shared counter: cleared on every state change, saturates while a state persists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (state_n != state) begin
                cnt <= '0;
            end else if (cnt != {CW{1'b1}}) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_comb begin
        state_n  = state;
        w_ready  = 1'b0;
        c_ready  = 1'b0;
        r_valid  = 1'b0;
        m_start  = 1'b0;
        w_take   = 1'b0;
        c_take   = 1'b0;
        cap_take = 1'b0;
        tmo_take = 1'b0;
        case (state)
            S_IDLE: begin
                // Compute has priority; a write is only offered when no compute is pending.
                c_ready = !rst;
                w_ready = !rst && !c_valid;
                if (c_valid && c_ready) begin
                    c_take  = 1'b1;
                    state_n = S_START;
                end else if (w_valid && w_ready) begin
                    w_take  = 1'b1;
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cnt == CW'(WR_CYC - 1)) begin
                    state_n = S_IDLE;
                end
            end
            S_START: begin
                m_start = 1'b1;
                state_n = S_BUSY;
            end
            S_BUSY: begin
                if (m_st) begin
                    if (RES_DLY == 0) begin
                        cap_take = 1'b1;
                        state_n  = S_RESP;
                    end else begin
                        state_n  = S_CAPTURE;
                    end
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    tmo_take = 1'b1;
                    state_n  = S_RESP;
                end
            end
            S_CAPTURE: begin
                if (cnt == CW'(RES_DLY - 1)) begin
                    cap_take = 1'b1;
                    state_n  = S_RESP;
                end
            end
            S_RESP: begin
                r_valid = 1'b1;
                if (r_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Macro pins only change on command accept, so they stay put through WRITE/BUSY and after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_D       <= '0;
            m_WA      <= '0;
            m_cima    <= 1'b0;
            m_xin0    <= '0;
            m_inwidth <= 1'b0;
            m_wwidth  <= 1'b0;
            m_acm_en  <= 1'b0;
            r_data    <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_take) begin
                m_D    <= w_data;
                m_WA   <= w_addr;
                m_cima <= w_bank;
            end
            if (c_take) begin
                m_xin0    <= c_xin;
                m_cima    <= c_bank;
                m_inwidth <= c_inwidth;
                m_wwidth  <= c_wwidth;
                m_acm_en  <= c_acc;
            end
            if (cap_take) begin
                r_data <= m_nout;
                r_err  <= 1'b0;
            end
            if (tmo_take) begin
                r_data <= '0;
                r_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcim_macro_driver.sv
// tb/tb_dcim_macro_driver.sv - self-checking bench for dcim_macro_driver
module tb_dcim_macro_driver;

    logic         clk = 1'b0;
    logic         rst;
    logic         w_valid;
    logic         w_ready;
    logic [23:0]  w_data;
    logic [7:0]   w_addr;
    logic         w_bank;
    logic         c_valid;
    logic         c_ready;
    logic [191:0] c_xin;
    logic         c_bank;
    logic         c_inwidth;
    logic         c_wwidth;
    logic         c_acc;
    logic         r_valid;
    logic         r_ready;
    logic [50:0]  r_data;
    logic         r_err;
    logic [23:0]  m_D;
    logic [7:0]   m_WA;
    logic         m_cima;
    logic         m_start;
    logic [191:0] m_xin0;
    logic         m_inwidth;
    logic         m_wwidth;
    logic         m_acm_en;
    logic [50:0]  m_nout = '0;
    logic         m_st = 1'b0;

    dcim_macro_driver dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_addr(w_addr), .w_bank(w_bank),
        .c_valid(c_valid), .c_ready(c_ready), .c_xin(c_xin), .c_bank(c_bank),
        .c_inwidth(c_inwidth), .c_wwidth(c_wwidth), .c_acc(c_acc),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_err(r_err),
        .m_D(m_D), .m_WA(m_WA), .m_cima(m_cima), .m_start(m_start), .m_xin0(m_xin0),
        .m_inwidth(m_inwidth), .m_wwidth(m_wwidth), .m_acm_en(m_acm_en),
        .m_nout(m_nout), .m_st(m_st)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        err;
        logic [50:0] data;
    } resp_t;
    resp_t exp_q[$];
    resp_t mon_e;

    // Macro model: st pulses st_dly cycles after start; nout valid only for st cycle and the next.
    int          st_dly = -1;
    bit          st_at_start = 1'b0;
    bit          st_force = 1'b0;
    logic [50:0] nout_val = '0;
    int          st_cnt = -1;
    int          post_cnt = 0;

    always @(posedge clk) begin
        #2;
        m_st = st_force;
        if (post_cnt > 0) begin
            post_cnt--;
            if (post_cnt == 0) m_nout = ~nout_val;
        end
        if (st_cnt > 0) begin
            st_cnt--;
            if (st_cnt == 0) begin
                m_st     = 1'b1;
                m_nout   = nout_val;
                post_cnt = 2;
                st_cnt   = -1;
            end
        end
        if (m_start) begin
            if (st_at_start) m_st = 1'b1;
            if (st_dly > 0) st_cnt = st_dly;
        end
    end

    always @(negedge clk) begin
        if (!rst && r_valid && r_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected got err=%b data=%h", r_err, r_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({r_err, r_data} !== mon_e) begin
                    errors++;
                    $display("FAIL resp_data got err=%b data=%h exp err=%b data=%h",
                             r_err, r_data, mon_e.err, mon_e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_compute(input logic [191:0] xin, input logic bank, input logic iw,
                                 input logic ww, input logic acc, input logic push,
                                 input logic err, input logic [50:0] data);
        int n;
        c_xin = xin; c_bank = bank; c_inwidth = iw; c_wwidth = ww; c_acc = acc;
        c_valid = 1'b1;
        #1;
        n = 0;
        while (!c_ready && n < 200) begin step(); n++; end
        if (n >= 200) begin
            errors++; checks++;
            $display("FAIL compute_accept_timeout c_ready=%b", c_ready);
        end
        if (push) exp_q.push_back({err, data});
        @(posedge clk);
        #1;
        c_valid = 1'b0;
    endtask

    task automatic issue_write(input logic [7:0] addr, input logic [23:0] data, input logic bank);
        int n;
        w_addr = addr; w_data = data; w_bank = bank;
        w_valid = 1'b1;
        #1;
        n = 0;
        while (!w_ready && n < 200) begin step(); n++; end
        if (n >= 200) begin
            errors++; checks++;
            $display("FAIL write_accept_timeout w_ready=%b", w_ready);
        end
        @(posedge clk);
        #1;
        w_valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin step(); n++; end
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        w_valid = 0; w_data = '0; w_addr = '0; w_bank = 0;
        c_valid = 0; c_xin = '0; c_bank = 0; c_inwidth = 0; c_wwidth = 0; c_acc = 0;
        r_ready = 0;
        step(); step();
        checks++;
        if ({w_ready, c_ready, r_valid, m_start, m_cima, m_inwidth, m_wwidth, m_acm_en, r_err} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 0", {w_ready, c_ready, r_valid, m_start, m_cima,
                     m_inwidth, m_wwidth, m_acm_en, r_err});
        end
        checks++;
        if ({m_D, m_WA, m_xin0} !== '0) begin
            errors++;
            $display("FAIL reset_pins got D=%h WA=%h xin0=%h required 0", m_D, m_WA, m_xin0);
        end
        checks++;
        if (r_data !== 51'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h required 0", r_data);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({c_ready, w_ready} !== 2'b11) begin
            errors++;
            $display("FAIL idle_ready got c=%b w=%b required 1 1", c_ready, w_ready);
        end
    endtask

    task automatic test_write();
        int hold;
        bit bad;
        issue_write(8'h05, 24'hABCDEF, 1'b1);
        hold = 0;
        bad = 0;
        while (!w_ready && hold < 20) begin
            if (m_WA !== 8'h05 || m_D !== 24'hABCDEF || m_cima !== 1'b1 || c_ready !== 1'b0) bad = 1;
            hold++;
            step();
        end
        checks++;
        if (hold != 2) begin
            errors++;
            $display("FAIL write_hold_cycles got %0d required 2", hold);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL write_pins_during_hold got WA=%h D=%h cima=%b required 05 abcdef 1",
                     m_WA, m_D, m_cima);
        end
        checks++;
        if (m_WA !== 8'h05 || m_D !== 24'hABCDEF || m_cima !== 1'b1) begin
            errors++;
            $display("FAIL write_pins_retained got WA=%h D=%h cima=%b required 05 abcdef 1",
                     m_WA, m_D, m_cima);
        end
    endtask

    task automatic test_compute();
        logic [191:0] xin;
        int n;
        xin = {6{32'hC0DE_0001}} ^ 192'h5A;
        r_ready = 1'b1;
        st_at_start = 0; st_dly = 7; nout_val = 51'h1234;
        issue_compute(xin, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 51'h1234);
        checks++;
        if (m_start !== 1'b1 || m_xin0 !== xin || m_cima !== 1'b0 ||
            {m_inwidth, m_wwidth, m_acm_en} !== 3'b101) begin
            errors++;
            $display("FAIL compute_pins got start=%b cima=%b flags=%b xin_ok=%b required 1 0 101 1",
                     m_start, m_cima, {m_inwidth, m_wwidth, m_acm_en}, m_xin0 === xin);
        end
        step();
        checks++;
        if (m_start !== 1'b0 || c_ready !== 1'b0 || w_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_pulse got start=%b c_ready=%b w_ready=%b required 0 0 0",
                     m_start, c_ready, w_ready);
        end
        n = 1;
        while (!r_valid && n < 100) begin step(); n++; end
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL compute_latency got %0d required 9", n);
        end
        wait_drain(20);
    endtask

    task automatic test_priority();
        c_xin = {192{1'b1}}; c_bank = 1; c_inwidth = 0; c_wwidth = 1; c_acc = 0;
        w_addr = 8'h3C; w_data = 24'h135797; w_bank = 0;
        st_at_start = 0; st_dly = 4; nout_val = 51'h7_0000_0000_ABCD;
        c_valid = 1'b1;
        w_valid = 1'b1;
        #1;
        checks++;
        if ({c_ready, w_ready} !== 2'b10) begin
            errors++;
            $display("FAIL priority got c_ready=%b w_ready=%b required 1 0", c_ready, w_ready);
        end
        exp_q.push_back({1'b0, 51'h7_0000_0000_ABCD});
        step();
        c_valid = 1'b0;
        for (int i = 0; i < 200 && !w_ready; i++) step();
        checks++;
        if (!w_ready || exp_q.size() != 0 || r_valid) begin
            errors++;
            $display("FAIL write_after_resp got w_ready=%b pending=%0d r_valid=%b required 1 0 0",
                     w_ready, exp_q.size(), r_valid);
        end
        step();
        w_valid = 1'b0;
        checks++;
        if (m_WA !== 8'h3C || m_D !== 24'h135797 || m_cima !== 1'b0) begin
            errors++;
            $display("FAIL deferred_write got WA=%h D=%h cima=%b required 3c 135797 0", m_WA, m_D, m_cima);
        end
        step(); step();
    endtask

    task automatic test_timeout();
        int n;
        st_at_start = 0; st_dly = -1;
        issue_compute(192'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 51'h0);
        n = 0;
        while (!r_valid && n < 200) begin step(); n++; end
        checks++;
        if (n != 65 || r_err !== 1'b1 || r_data !== 51'h0) begin
            errors++;
            $display("FAIL timeout_resp got cycles=%0d err=%b data=%h required 65 1 0", n, r_err, r_data);
        end
        wait_drain(20);
        issue_write(8'hA7, 24'h00FF00, 1'b0);
        checks++;
        if (m_WA !== 8'hA7 || m_D !== 24'h00FF00) begin
            errors++;
            $display("FAIL write_after_timeout got WA=%h D=%h required a7 00ff00", m_WA, m_D);
        end
        step(); step(); step();
    endtask

    task automatic test_st_ignored();
        int n;
        st_force = 1'b1;
        step(); step();
        st_force = 1'b0;
        step(); step();
        checks++;
        if (r_valid !== 1'b0 || c_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_st_ignored got r_valid=%b c_ready=%b required 0 1", r_valid, c_ready);
        end
        st_at_start = 1; st_dly = 3; nout_val = 51'h2_BEEF_0000_0042;
        issue_compute(192'hFACE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 51'h2_BEEF_0000_0042);
        n = 0;
        while (!r_valid && n < 100) begin step(); n++; end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL start_st_ignored latency got %0d required 5", n);
        end
        st_at_start = 0;
        wait_drain(20);
    endtask

    task automatic test_backpressure();
        int n;
        logic [50:0] d0;
        bit bad;
        r_ready = 1'b0;
        st_dly = 2; nout_val = 51'h5_5555_AAAA_0001;
        issue_compute(192'h77, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 51'h5_5555_AAAA_0001);
        n = 0;
        while (!r_valid && n < 100) begin step(); n++; end
        d0 = r_data;
        c_valid = 1'b1; w_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (r_valid !== 1'b1 || r_data !== d0 || c_ready !== 1'b0 || w_ready !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL backpressure_hold got r_valid=%b data=%h c_ready=%b w_ready=%b required 1 %h 0 0",
                     r_valid, r_data, c_ready, w_ready, d0);
        end
        c_valid = 1'b0; w_valid = 1'b0;
        r_ready = 1'b1;
        wait_drain(20);
        checks++;
        if (r_valid !== 1'b0) begin
            errors++;
            $display("FAIL resp_release got r_valid=%b required 0", r_valid);
        end
    endtask

    task automatic test_reset_mid_busy();
        bit seen;
        st_dly = -1;
        issue_write(8'h99, 24'h123456, 1'b1);
        step(); step();
        issue_compute({3{64'hDEAD_BEEF_0BAD_F00D}}, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 51'h0);
        repeat (5) step();
        rst = 1'b1;
        #1;
        checks++;
        if ({w_ready, c_ready, r_valid, m_start, m_cima, m_inwidth, m_wwidth, m_acm_en, r_err} !== 9'b0 ||
            {m_D, m_WA, m_xin0, r_data} !== '0) begin
            errors++;
            $display("FAIL reset_mid_busy got ctrl=%b D=%h WA=%h xin_zero=%b rdata=%h required all 0",
                     {w_ready, c_ready, r_valid, m_start, m_cima, m_inwidth, m_wwidth, m_acm_en, r_err},
                     m_D, m_WA, m_xin0 == '0, r_data);
        end
        exp_q.delete();
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (r_valid) seen = 1;
        end
        checks++;
        if (seen || c_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_discard got r_valid_seen=%b c_ready=%b required 0 1", seen, c_ready);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_compute();
        test_priority();
        test_timeout();
        test_st_ignored();
        test_backpressure();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
